// File: rtl/mcu0_intc_pkg.sv
// mcu0_intc_pkg
// Shared definitions for the mcu0 interrupt controller:
//   NSRC          number of interrupt sources
//   state_t       request/service state machine encoding
//   ADDR_*        config register addresses
//   onehot()      index to one-hot source vector
package mcu0_intc_pkg;

    localparam int NSRC = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [1:0] ADDR_ISR  = 2'd3;

    function automatic logic [NSRC-1:0] onehot(input logic [2:0] idx);
        logic [NSRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mcu0_intc_if.sv
// mcu0_intc_if
// Bus bundle between the mcu0 core side (master) and the interrupt
// controller (slave).
//   src        raw peripheral interrupt lines
//   cfg_*      config register write strobe / address / data, and read data
//   interrupt  request to the core
//   irq        index of the requested source
//   int_ack    core takes the interrupt (one-cycle pulse)
//   eoi        core executes IRET (one-cycle pulse)
interface mcu0_intc_if;
    import mcu0_intc_pkg::*;

    logic [NSRC-1:0] src;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [7:0]      cfg_wdata;
    logic [7:0]      cfg_rdata;
    logic            interrupt;
    logic [2:0]      irq;
    logic            int_ack;
    logic            eoi;

    modport master (
        output src, cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
        input  cfg_rdata, interrupt, irq
    );

    modport slave (
        input  src, cfg_we, cfg_addr, cfg_wdata, int_ack, eoi,
        output cfg_rdata, interrupt, irq
    );

endinterface

// File: rtl/mcu0_intc_prio_enc.sv
// mcu0_prio_enc
// Rotating 8->3 priority encoder. The search begins at i_start and wraps
// from 7 to 0; i_start = 0 gives fixed priority with source 0 highest.
//   i_req    request vector
//   i_start  first index searched
//   o_valid  any request present
//   o_index  index of the winning request
module mcu0_prio_enc
    import mcu0_intc_pkg::*;
(
    input  logic [NSRC-1:0] i_req,
    input  logic [2:0]      i_start,
    output logic            o_valid,
    output logic [2:0]      o_index
);

    logic       w_found;
    logic [2:0] w_idx;

    always_comb begin
        w_found = 1'b0;
        w_idx   = 3'd0;
        o_index = 3'd0;
        for (int i = 0; i < NSRC; i++) begin
            // 3-bit add wraps naturally from 7 back to 0
            w_idx = i_start + 3'(i);
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                o_index = w_idx;
            end
        end
        o_valid = w_found;
    end

endmodule

// File: rtl/mcu0_intc.sv
// mcu0_intc
// Eight-source interrupt controller for the mcu0 core. Latches and masks
// the peripheral lines, picks one source by fixed or round-robin priority,
// requests it on `interrupt`/`irq`, and tracks it in service until IRET.
// No nesting: while a source is in service no new request is raised.
//   RR     0 = fixed priority, 1 = round-robin after last acked source
//   clock  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    mcu0_intc_if slave: src, cfg_*, interrupt, irq, int_ack, eoi
//
// State table
//   ST_IDLE    | no request outstanding, searching eligible sources
//   ST_REQ     | interrupt raised for irq, waiting for int_ack
//   ST_SERVICE | handler running for irq, waiting for eoi
module mcu0_intc
    import mcu0_intc_pkg::*;
#(
    parameter bit RR = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    mcu0_intc_if.slave bus
);

    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_isr;
    logic [NSRC-1:0] r_src_q;
    logic [2:0]      r_ptr;
    state_t          r_state;
    logic            r_interrupt;
    logic [2:0]      r_irq;

    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_pend_nxt;
    logic [NSRC-1:0] w_elig;
    logic            w_ack_take;
    logic [2:0]      w_start;
    logic            w_valid;
    logic [2:0]      w_index;

    // ---------------- config registers ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
            r_edge <= '0;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                ADDR_MASK: r_mask <= bus.cfg_wdata;
                ADDR_EDGE: r_edge <= bus.cfg_wdata;
                default:   ;
            endcase
        end
    end

    always_comb begin
        case (bus.cfg_addr)
            ADDR_MASK: bus.cfg_rdata = r_mask;
            ADDR_EDGE: bus.cfg_rdata = r_edge;
            ADDR_PEND: bus.cfg_rdata = r_pend;
            default:   bus.cfg_rdata = r_isr;
        endcase
    end

    // ---------------- pending latch ----------------
    assign w_ack_take = (r_state == ST_REQ) && bus.int_ack;
    assign w_rise     = bus.src & ~r_src_q;
    assign w_w1c      = (bus.cfg_we && bus.cfg_addr == ADDR_PEND) ? bus.cfg_wdata : '0;
    assign w_ack_clr  = w_ack_take ? onehot(r_irq) : '0;

    // A fresh edge overrides both the W1C and the ack clear in the same cycle,
    // so an event arriving exactly as the old one is retired is never lost.
    assign w_pend_nxt = (r_edge & (w_rise | (r_pend & ~(w_w1c | w_ack_clr))))
                      | (~r_edge & bus.src);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend  <= '0;
            r_src_q <= '0;
        end else begin
            r_pend  <= w_pend_nxt;
            r_src_q <= bus.src;
        end
    end

    // ---------------- priority selection ----------------
    assign w_elig  = r_pend & r_mask;
    assign w_start = RR ? (r_ptr + 3'd1) : 3'd0;

    mcu0_prio_enc u_prio_enc (
        .i_req   (w_elig),
        .i_start (w_start),
        .o_valid (w_valid),
        .o_index (w_index)
    );

    // ---------------- request / service FSM ----------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_interrupt <= 1'b0;
            r_irq       <= 3'd0;
            r_isr       <= '0;
            r_ptr       <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_irq       <= w_index;
                        r_interrupt <= 1'b1;
                        r_state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // ack takes precedence over a simultaneous withdrawal
                    if (bus.int_ack) begin
                        r_isr       <= onehot(r_irq);
                        r_ptr       <= r_irq;
                        r_interrupt <= 1'b0;
                        r_state     <= ST_SERVICE;
                    end else if (!w_elig[r_irq]) begin
                        r_interrupt <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eoi) begin
                        r_isr   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_interrupt <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.interrupt = r_interrupt;
    assign bus.irq       = r_irq;

endmodule

// File: tb/tb_mcu0_intc.sv
// tb_mcu0_intc
// Drives a fixed-priority and a round-robin controller with identical
// stimulus: directed scenarios with hand-derived expectations, then random
// traffic compared cycle by cycle against a behavioural model.
module tb_mcu0_intc;

    logic       clock;
    logic       reset;
    logic [7:0] src;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       int_ack;
    logic       eoi;

    int n_pass;
    int n_chk;

    mcu0_intc_if if_fx ();
    mcu0_intc_if if_rr ();

    assign if_fx.src = src;       assign if_rr.src = src;
    assign if_fx.cfg_we = cfg_we; assign if_rr.cfg_we = cfg_we;
    assign if_fx.cfg_addr = cfg_addr;   assign if_rr.cfg_addr = cfg_addr;
    assign if_fx.cfg_wdata = cfg_wdata; assign if_rr.cfg_wdata = cfg_wdata;
    assign if_fx.int_ack = int_ack; assign if_rr.int_ack = int_ack;
    assign if_fx.eoi = eoi;         assign if_rr.eoi = eoi;

    mcu0_intc #(.RR(1'b0)) dut_fx (.clock(clock), .reset(reset), .bus(if_fx));
    mcu0_intc #(.RR(1'b1)) dut_rr (.clock(clock), .reset(reset), .bus(if_rr));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model (index 0 = fixed, 1 = round-robin) ----------------
    bit [7:0] m_mask [2];
    bit [7:0] m_edge [2];
    bit       m_pend [2][8];
    bit       m_srcq [2][8];
    bit       m_req  [2];
    int       m_irq  [2];
    int       m_isr  [2];   // source in service, -1 when none
    int       m_last [2];   // last acknowledged source

    task automatic model_reset(input int d);
        m_mask[d] = 8'h00;
        m_edge[d] = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_pend[d][i] = 1'b0;
            m_srcq[d][i] = 1'b0;
        end
        m_req[d]  = 1'b0;
        m_irq[d]  = 0;
        m_isr[d]  = -1;
        m_last[d] = 0;
    endtask

    task automatic model_step(input int d, input bit rr);
        bit elig [8];
        bit np   [8];
        bit rise;
        bit clr;
        int start;
        int win;
        for (int i = 0; i < 8; i++) elig[i] = m_pend[d][i] && m_mask[d][i];
        for (int i = 0; i < 8; i++) begin
            if (m_edge[d][i]) begin
                rise  = src[i] && !m_srcq[d][i];
                clr   = (cfg_we && cfg_addr == 2'd2 && cfg_wdata[i])
                     || (m_req[d] && int_ack && m_irq[d] == i);
                np[i] = rise || (m_pend[d][i] && !clr);
            end else begin
                np[i] = src[i];
            end
        end
        if (m_req[d]) begin
            if (int_ack) begin
                m_isr[d]  = m_irq[d];
                m_last[d] = m_irq[d];
                m_req[d]  = 1'b0;
            end else if (!elig[m_irq[d]]) begin
                m_req[d] = 1'b0;
            end
        end else if (m_isr[d] >= 0) begin
            if (eoi) m_isr[d] = -1;
        end else begin
            start = rr ? (m_last[d] + 1) % 8 : 0;
            win   = -1;
            for (int k = 0; k < 8; k++) begin
                if (win < 0 && elig[(start + k) % 8]) win = (start + k) % 8;
            end
            if (win >= 0) begin
                m_req[d] = 1'b1;
                m_irq[d] = win;
            end
        end
        if (cfg_we && cfg_addr == 2'd0) m_mask[d] = cfg_wdata;
        if (cfg_we && cfg_addr == 2'd1) m_edge[d] = cfg_wdata;
        for (int i = 0; i < 8; i++) begin
            m_pend[d][i] = np[i];
            m_srcq[d][i] = src[i];
        end
    endtask

    function automatic logic [7:0] model_rdata(input int d, input logic [1:0] a);
        logic [7:0] v;
        v = 8'h00;
        case (a)
            2'd0: v = m_mask[d];
            2'd1: v = m_edge[d];
            2'd2: for (int i = 0; i < 8; i++) v[i] = m_pend[d][i];
            default: if (m_isr[d] >= 0) v[m_isr[d]] = 1'b1;
        endcase
        return v;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    endtask

    task automatic tick();
        if (reset) begin
            model_reset(0);
            model_reset(1);
        end else begin
            model_step(0, 1'b0);
            model_step(1, 1'b1);
        end
        @(posedge clock);
        #1;
        chk("fx_interrupt", 8'(if_fx.interrupt), 8'(m_req[0]));
        chk("fx_irq",       8'(if_fx.irq),       8'(m_irq[0]));
        chk("fx_rdata",     if_fx.cfg_rdata,     model_rdata(0, cfg_addr));
        chk("rr_interrupt", 8'(if_rr.interrupt), 8'(m_req[1]));
        chk("rr_irq",       8'(if_rr.irq),       8'(m_irq[1]));
        chk("rr_rdata",     if_rr.cfg_rdata,     model_rdata(1, cfg_addr));
    endtask

    task automatic rd(input string tag, input logic [1:0] a,
                      input logic [7:0] ex_fx, input logic [7:0] ex_rr);
        cfg_addr = a;
        #1;
        chk({tag, "_fx"}, if_fx.cfg_rdata, ex_fx);
        chk({tag, "_rr"}, if_rr.cfg_rdata, ex_rr);
    endtask

    task automatic chk_out(input string tag, input logic ex_int_fx, input logic [2:0] ex_irq_fx,
                           input logic ex_int_rr, input logic [2:0] ex_irq_rr);
        chk({tag, "_int_fx"}, 8'(if_fx.interrupt), 8'(ex_int_fx));
        chk({tag, "_irq_fx"}, 8'(if_fx.irq),       8'(ex_irq_fx));
        chk({tag, "_int_rr"}, 8'(if_rr.interrupt), 8'(ex_int_rr));
        chk({tag, "_irq_rr"}, 8'(if_rr.irq),       8'(ex_irq_rr));
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] dat);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = dat;
        tick();
        cfg_we = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_pass = 0;
        n_chk  = 0;
        reset = 1'b1; src = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
        model_reset(0);
        model_reset(1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk_out("reset", 1'b0, 3'd0, 1'b0, 3'd0);
        rd("reset_mask", 2'd0, 8'h00, 8'h00);

        wr(2'd0, 8'hFF);
        wr(2'd1, 8'hFF);

        // sources 2 and 6 together; RR pointer starts at 0 so both pick 2
        src = 8'h44; tick();
        src = 8'h00; tick();
        chk_out("pair_first", 1'b1, 3'd2, 1'b1, 3'd2);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd("pair_isr", 2'd3, 8'h04, 8'h04);
        // edge on source 1 while 2 is in service
        src = 8'h02; tick();
        src = 8'h00; tick();
        chk_out("svc_hold", 1'b0, 3'd2, 1'b0, 3'd2);
        rd("svc_pend", 2'd2, 8'h42, 8'h42);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        // fixed: 1 beats 6; round-robin from pointer 2: 6 comes first
        chk_out("after_eoi", 1'b1, 3'd1, 1'b1, 3'd6);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk_out("second", 1'b1, 3'd6, 1'b1, 3'd1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk_out("drained", 1'b0, 3'd6, 1'b0, 3'd1);

        // single edge pulse on source 5, two-cycle latency
        src = 8'h20; tick();
        src = 8'h00;
        chk_out("s5_lat1", 1'b0, 3'd6, 1'b0, 3'd1);
        tick();
        chk_out("s5_req", 1'b1, 3'd5, 1'b1, 3'd5);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd("s5_pend", 2'd2, 8'h00, 8'h00);
        rd("s5_isr",  2'd3, 8'h20, 8'h20);
        eoi = 1'b1; tick(); eoi = 1'b0;
        rd("s5_eoi",  2'd3, 8'h00, 8'h00);

        // level source 3 withdrawn before ack, then a late ack
        wr(2'd1, 8'hF7);
        src = 8'h08; tick();
        tick();
        chk_out("lvl_req", 1'b1, 3'd3, 1'b1, 3'd3);
        src = 8'h00; tick();
        tick();
        chk_out("lvl_drop", 1'b0, 3'd3, 1'b0, 3'd3);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        rd("lvl_isr", 2'd3, 8'h00, 8'h00);
        wr(2'd1, 8'hFF);

        // W1C, fresh edge and ack on source 0 in one cycle
        src = 8'h01; tick();
        src = 8'h00; tick();
        chk_out("w1c_req", 1'b1, 3'd0, 1'b1, 3'd0);
        src = 8'h01; cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h01; int_ack = 1'b1;
        tick();
        src = 8'h00; cfg_we = 1'b0; int_ack = 1'b0;
        rd("w1c_isr",  2'd3, 8'h01, 8'h01);
        rd("w1c_pend", 2'd2, 8'h01, 8'h01);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        chk_out("w1c_again", 1'b1, 3'd0, 1'b1, 3'd0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // asynchronous reset in the middle of servicing source 3
        src = 8'h08; tick();
        src = 8'h00; tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        src = 8'h80; tick();
        src = 8'h00; tick();
        reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 3'd0, 1'b0, 3'd0);
        rd("rst_mask", 2'd0, 8'h00, 8'h00);
        rd("rst_pend", 2'd2, 8'h00, 8'h00);
        rd("rst_isr",  2'd3, 8'h00, 8'h00);
        model_reset(0);
        model_reset(1);
        tick();
        reset = 1'b0;
        tick();

        // random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) src = 8'($urandom);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = 8'($urandom);
            int_ack   = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mcu0_intc.md
# mcu0_intc

Eight-source interrupt controller for the mcu0 core. It latches and masks the peripheral interrupt lines and selects one source by priority. It drives the core's single `interrupt` line and 3-bit `irq` vector, and tracks the source in service until the handler's IRET. There is no nesting, which matches the core's single-level LR/I-flag model.

## Interface
- `RR`, default 0: 0 = fixed priority (source 0 highest); 1 = round-robin starting after the last acknowledged source.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `src`  in  8  raw interrupt sources, synchronous to `clock`.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  2  register select: 0 MASK, 1 EDGE, 2 PEND, 3 ISR.
- `cfg_wdata`  in  8  write data.
- `cfg_rdata`  out  8  combinational read of the selected register.
- `interrupt`  out  1  request to the core.
- `irq`  out  3  vector/index of the requested source.
- `int_ack`  in  1  one-cycle pulse from the core in the cycle it vectors to `irq`.
- `eoi`  in  1  one-cycle pulse from the core on IRET.

## Operation
- Registers:
  - MASK: read/write, 1 = source enabled.
  - EDGE: read/write, 1 = rising-edge mode, 0 = level mode.
  - PEND: read; writing 1 clears an edge-mode bit; level-mode bits ignore writes.
  - ISR: read-only; at most one bit set.
- Reset clears `interrupt`, `irq`, MASK, EDGE, PEND, ISR, `src_q`, and the RR pointer, and sets the FSM to IDLE.
- Pending, registered each cycle:
  - Edge-mode bit: set on `src & ~src_q` and held until acked or W1C-cleared.
  - Level-mode bit: follows `src`.
  - An edge and a W1C clear on the same bit in the same cycle: set wins.
  - A second edge while a bit is already pending is absorbed; there is no counting.
- Eligible = PEND & MASK.
- FSM states and transitions:
  - IDLE:
    - If eligible ≠ 0, latch the winner into `irq`, go to REQ, and assert `interrupt`.
  - REQ:
    - `interrupt` = 1 and `irq` is held stable.
    - On `int_ack`: clear the edge-mode PEND bit of `irq`, set ISR[`irq`], update the RR pointer to `irq`, drop `interrupt`, and go to SERVICE.
    - If the latched source leaves eligible with no ack (masked, W1C-cleared, or level dropped): drop `interrupt` and return to IDLE.
    - If ack and withdrawal happen in the same cycle: ack wins.
    - A higher-priority source arriving in REQ does not preempt.
  - SERVICE:
    - `interrupt` = 0 and no new request is issued.
    - On `eoi`: clear ISR and go to IDLE.
- Stray pulses: `int_ack` outside REQ and `eoi` outside SERVICE are ignored.
- Edges that arrive during SERVICE pend normally, including an edge on the source in service.
- RR = 1: the search starts at (pointer + 1) mod 8 and wraps from 7 to 0.
- Integration: the core pulses `int_ack` when it takes the interrupt (`!I && interrupt`) and pulses `eoi` when it executes IRET.

## Timing
- Edge source:
  - `src` rises before edge k: PEND is set at edge k.
  - FSM enters REQ at edge k+1, so `interrupt` is high after edge k+1 (2-cycle latency).
  - Level sources have the same 2-cycle latency.
- `int_ack` sampled at edge j: `interrupt` is low after edge j.
- `eoi` sampled at edge e: the FSM is in IDLE after edge e. A next request that is already pending is re-asserted after edge e+1.
- Config:
  - A write is effective at the same edge.
  - A MASK write that disables the source in REQ drops `interrupt` after the following edge.
- `reset` asserted mid-REQ or mid-SERVICE: outputs go low immediately (asynchronous); all pending requests are lost.

## Structure
- Package `mcu0_intc_pkg` holds:
  - the state enum (IDLE, REQ, SERVICE);
  - register address constants (MASK=0, EDGE=1, PEND=2, ISR=3);
  - `NSRC=8`.
- Sub-module `mcu0_prio_enc`: 8→3 rotating priority encoder.
  - Inputs: request vector and 3-bit start index.
  - Outputs: `valid` and `index`.
  - Fixed priority is start index 0.

## Test plan
- MASK=0xFF, EDGE=0xFF, pulse `src[5]` for one cycle:
  - `interrupt` goes high 2 cycles later with `irq`=5.
  - `int_ack` → PEND=0x00, ISR=0x20.
  - `eoi` → ISR=0x00.
- Fixed priority, `src[6]` and `src[2]` rise in the same cycle:
  - `irq`=2 first.
  - After ack and eoi, `irq`=6.
  - RR=1 with pointer at 2 and sources 1 and 6 pending gives `irq`=6.
- Level mode, `src[3]` held high through REQ then dropped before ack:
  - `interrupt` drops and the FSM returns to IDLE.
  - A late `int_ack` is ignored and ISR stays 0x00.
- During SERVICE of source 4, pulse `src[1]`:
  - `interrupt` stays 0 and PEND=0x02.
  - After `eoi`, `interrupt` rises with `irq`=1.
- In REQ with `irq`=0, write PEND=0x01 (W1C) in the same cycle `src[0]` rises again while `int_ack` pulses:
  - ack is taken and ISR=0x01.
  - PEND[0]=1, because set wins.
- Assert `reset` mid-SERVICE:
  - `interrupt`, `irq`, MASK, PEND, and ISR are all 0 immediately, before the next clock edge.
